// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: the upstream and downstream
// valid/ready/payload pairs, plus flush, sticky halt and the stall counter.
interface pipe_stage_reg_if #(
   parameter int unsigned DW = 128,
   parameter int unsigned CW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_halt;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_halt;
   logic          halted;
   logic [CW-1:0] stall_cnt;

   // Side that feeds the stage and consumes its output (pipeline control / bench).
   modport master (
      output in_valid, in_data, in_halt, flush, out_ready,
      input  in_ready, out_valid, out_data, out_halt, halted, stall_cnt
   );

   // The stage register itself.
   modport slave (
      input  in_valid, in_data, in_halt, flush, out_ready,
      output in_ready, out_valid, out_data, out_halt, halted, stall_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: DW-bit payload + halt flag, valid/ready on both
// sides, synchronous flush, optional skid entry, sticky halt and saturating stall count.
module pipe_stage_reg #(
   parameter int unsigned DW   = 128,
   parameter int unsigned SKID = 1,
   parameter int unsigned CW   = 16
) (
   input logic              CLK,
   input logic              nRST,
   pipe_stage_reg_if.slave  bus
);

   typedef enum logic [1:0] {StEmpty, StMain, StBoth} state_e;

   logic          in_ready;
   logic          in_xfer;
   logic          out_xfer;
   logic          halted_q, halted_d;
   logic [CW-1:0] stall_q, stall_d;
   logic          main_valid_q, main_valid_d;
   logic [DW-1:0] main_data_q, main_data_d;
   logic          main_halt_q, main_halt_d;

   assign in_xfer  = bus.in_valid && in_ready;
   assign out_xfer = main_valid_q && bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = main_valid_q;
   assign bus.out_data  = main_data_q;
   assign bus.out_halt  = main_halt_q;
   assign bus.halted    = halted_q;
   assign bus.stall_cnt = stall_q;

   // Halt sticks once the halt word has actually left; stall count saturates.
   always_comb begin
      halted_d = halted_q || (out_xfer && main_halt_q);
      stall_d  = stall_q;
      if (main_valid_q && !bus.out_ready && (stall_q != {CW{1'b1}})) begin
         stall_d = stall_q + CW'(1);
      end
   end

   // Status registers; flush deliberately leaves these alone.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         halted_q <= 1'b0;
         stall_q  <= '0;
      end else begin
         halted_q <= halted_d;
         stall_q  <= stall_d;
      end
   end

   // Main (output-facing) entry.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_halt_q  <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_halt_q  <= main_halt_d;
      end
   end

   if (SKID == 0) begin : g_single
      // Ready passes straight through from downstream when a word is held.
      assign in_ready = !halted_q && (bus.out_ready || !main_valid_q);

      // Load on input transfer, otherwise drain on output transfer; flush wins.
      always_comb begin
         main_valid_d = main_valid_q;
         main_data_d  = main_data_q;
         main_halt_d  = main_halt_q;
         if (bus.flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            main_halt_d  = 1'b0;
         end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_data_d  = bus.in_data;
            main_halt_d  = bus.in_halt;
         end else if (out_xfer) begin
            main_valid_d = 1'b0;
         end
      end
   end else begin : g_skid
      state_e        state_q, state_d;
      logic [DW-1:0] skid_data_q, skid_data_d;
      logic          skid_halt_q, skid_halt_d;
      logic          in_ready_q, in_ready_d;

      assign in_ready = in_ready_q;

      // Next-state: the skid entry absorbs the one word accepted while stalled.
      always_comb begin
         state_d     = state_q;
         main_data_d = main_data_q;
         main_halt_d = main_halt_q;
         skid_data_d = skid_data_q;
         skid_halt_d = skid_halt_q;
         case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  state_d     = StMain;
                  main_data_d = bus.in_data;
                  main_halt_d = bus.in_halt;
               end
            end
            StMain: begin
               if (in_xfer && out_xfer) begin
                  main_data_d = bus.in_data;
                  main_halt_d = bus.in_halt;
               end else if (in_xfer) begin
                  state_d     = StBoth;
                  skid_data_d = bus.in_data;
                  skid_halt_d = bus.in_halt;
               end else if (out_xfer) begin
                  state_d = StEmpty;
               end
            end
            StBoth: begin
               if (out_xfer) begin
                  state_d     = StMain;
                  main_data_d = skid_data_q;
                  main_halt_d = skid_halt_q;
               end
            end
            default: state_d = StEmpty;
         endcase
         if (bus.flush) begin
            state_d     = StEmpty;
            main_data_d = '0;
            main_halt_d = 1'b0;
         end
         main_valid_d = (state_d != StEmpty);
         in_ready_d   = !halted_d && (state_d != StBoth);
      end

      // Skid state, skid entry and registered ready.
      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            state_q     <= StEmpty;
            skid_data_q <= '0;
            skid_halt_q <= 1'b0;
            in_ready_q  <= 1'b1;
         end else begin
            state_q     <= state_d;
            skid_data_q <= skid_data_d;
            skid_halt_q <= skid_halt_d;
            in_ready_q  <= in_ready_d;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: u_a is the skid variant, u_b the single-register variant
// with a 3-bit stall counter so saturation is reachable.
module tb_pipe_stage_reg;

   localparam int unsigned DW = 32;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;
   always #5 CLK = ~CLK;

   pipe_stage_reg_if #(.DW(DW), .CW(16)) a_if ();
   pipe_stage_reg_if #(.DW(DW), .CW(3))  b_if ();

   pipe_stage_reg #(.DW(DW), .SKID(1), .CW(16)) u_a (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (a_if.slave)
   );

   pipe_stage_reg #(.DW(DW), .SKID(0), .CW(3)) u_b (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (b_if.slave)
   );

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic          iv;
      logic [31:0]   d;
      logic          fl;
      logic          rdy;
      logic          e_ir;
      logic          e_ov;
      logic [31:0]   e_od;
      logic          chk_d;
      logic [15:0]   e_sc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(logic iv, logic [31:0] d, logic fl, logic rdy, logic e_ir,
                                logic e_ov, logic [31:0] e_od, logic chk_d, logic [15:0] e_sc);
      vec_t r;
      r.iv = iv; r.d = d; r.fl = fl; r.rdy = rdy; r.e_ir = e_ir;
      r.e_ov = e_ov; r.e_od = e_od; r.chk_d = chk_d; r.e_sc = e_sc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drv_a(input logic iv, input logic [31:0] d, input logic h, input logic fl,
                        input logic rdy);
      a_if.in_valid = iv; a_if.in_data = d; a_if.in_halt = h; a_if.flush = fl;
      a_if.out_ready = rdy;
   endtask

   task automatic drv_b(input logic iv, input logic [31:0] d, input logic h, input logic fl,
                        input logic rdy);
      b_if.in_valid = iv; b_if.in_data = d; b_if.in_halt = h; b_if.flush = fl;
      b_if.out_ready = rdy;
   endtask

   initial begin
      drv_a(0, 0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0);
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      // Reset state of both variants.
      chk("a rst in_ready", a_if.in_ready, 1);
      chk("a rst out_valid", a_if.out_valid, 0);
      chk("a rst out_data", a_if.out_data, 0);
      chk("a rst out_halt", a_if.out_halt, 0);
      chk("a rst halted", a_if.halted, 0);
      chk("a rst stall_cnt", a_if.stall_cnt, 0);
      chk("b rst in_ready", b_if.in_ready, 1);
      chk("b rst out_valid", b_if.out_valid, 0);
      chk("b rst stall_cnt", b_if.stall_cnt, 0);
      nRST = 1'b1;

      // Skid variant: stream, backpressure, flush in BOTH and in MAIN.
      for (int k = 1; k <= 8; k++) vecs.push_back(mkv(1, k, 0, 1, 1, 1, k, 1, 0));
      vecs.push_back(mkv(0, 0,     0, 1, 1, 0, 0,     0, 0));
      vecs.push_back(mkv(1, 'hA,   0, 0, 1, 1, 'hA,   1, 0));
      vecs.push_back(mkv(1, 'hB,   0, 0, 0, 1, 'hA,   1, 1));
      vecs.push_back(mkv(0, 0,     0, 0, 0, 1, 'hA,   1, 2));
      vecs.push_back(mkv(0, 0,     0, 0, 0, 1, 'hA,   1, 3));
      vecs.push_back(mkv(0, 0,     0, 1, 1, 1, 'hB,   1, 3));
      vecs.push_back(mkv(0, 0,     0, 1, 1, 0, 0,     0, 3));
      vecs.push_back(mkv(1, 'h11,  0, 0, 1, 1, 'h11,  1, 3));
      vecs.push_back(mkv(1, 'h22,  0, 0, 0, 1, 'h11,  1, 4));
      vecs.push_back(mkv(1, 'h33,  1, 0, 1, 0, 0,     1, 5));
      vecs.push_back(mkv(1, 'h44,  0, 1, 1, 1, 'h44,  1, 5));
      vecs.push_back(mkv(1, 'h55,  1, 1, 1, 0, 0,     1, 5));
      vecs.push_back(mkv(1, 'h66,  0, 1, 1, 1, 'h66,  1, 5));
      vecs.push_back(mkv(0, 0,     0, 1, 1, 0, 0,     0, 5));

      #3;
      foreach (vecs[i]) begin
         drv_a(vecs[i].iv, vecs[i].d, 0, vecs[i].fl, vecs[i].rdy);
         tick();
         chk($sformatf("a v%0d in_ready", i), a_if.in_ready, vecs[i].e_ir);
         chk($sformatf("a v%0d out_valid", i), a_if.out_valid, vecs[i].e_ov);
         if (vecs[i].chk_d) chk($sformatf("a v%0d out_data", i), a_if.out_data, vecs[i].e_od);
         chk($sformatf("a v%0d stall_cnt", i), a_if.stall_cnt, vecs[i].e_sc);
      end

      // Async reset while in BOTH: outputs drop before the next clock edge.
      drv_a(1, 'h77, 0, 0, 0);
      tick();
      drv_a(1, 'h88, 0, 0, 0);
      tick();
      chk("a both in_ready", a_if.in_ready, 0);
      chk("a both out_data", a_if.out_data, 'h77);
      drv_a(0, 0, 0, 0, 0);
      #3 nRST = 1'b0;
      #1;
      chk("a arst out_valid", a_if.out_valid, 0);
      chk("a arst out_data", a_if.out_data, 0);
      chk("a arst in_ready", a_if.in_ready, 1);
      chk("a arst stall_cnt", a_if.stall_cnt, 0);
      #2 nRST = 1'b1;
      tick();
      chk("a post-rst out_valid", a_if.out_valid, 0);

      // Single-register variant: combinational ready and stall.
      drv_b(1, 'hA1, 0, 0, 0);
      #1 chk("b empty in_ready", b_if.in_ready, 1);
      tick();
      chk("b load out_data", b_if.out_data, 'hA1);
      chk("b stalled in_ready", b_if.in_ready, 0);
      drv_b(1, 'hB2, 0, 0, 0);
      tick();
      chk("b hold1 stall_cnt", b_if.stall_cnt, 1);
      tick();
      chk("b hold2 stall_cnt", b_if.stall_cnt, 2);
      chk("b hold out_data", b_if.out_data, 'hA1);
      drv_b(1, 'hB2, 0, 0, 1);
      #1 chk("b comb in_ready", b_if.in_ready, 1);
      tick();
      chk("b swap out_valid", b_if.out_valid, 1);
      chk("b swap out_data", b_if.out_data, 'hB2);
      drv_b(0, 0, 0, 0, 1);
      tick();
      chk("b drain out_valid", b_if.out_valid, 0);

      // Saturation of the 3-bit counter.
      drv_b(1, 'hC3, 0, 0, 0);
      tick();
      drv_b(0, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("b sat%0d stall_cnt", k), b_if.stall_cnt, (2 + k > 7) ? 7 : 2 + k);
      end
      drv_b(0, 0, 0, 0, 1);
      tick();
      chk("b sat drain stall_cnt", b_if.stall_cnt, 7);
      chk("b sat drain out_valid", b_if.out_valid, 0);

      // Flush beats a simultaneous input transfer.
      drv_b(1, 'hD4, 0, 0, 1);
      tick();
      chk("b pre-flush out_data", b_if.out_data, 'hD4);
      drv_b(1, 'hE5, 0, 1, 1);
      tick();
      chk("b flush out_valid", b_if.out_valid, 0);
      chk("b flush out_data", b_if.out_data, 0);
      drv_b(0, 0, 0, 0, 1);
      tick();
      chk("b flush dropped", b_if.out_valid, 0);

      // Halt on the single-register variant.
      drv_b(1, 'hF6, 1, 0, 1);
      tick();
      chk("b halt out_halt", b_if.out_halt, 1);
      chk("b halt not yet", b_if.halted, 0);
      drv_b(0, 0, 0, 0, 1);
      tick();
      chk("b halted", b_if.halted, 1);
      drv_b(1, 'h99, 0, 0, 1);
      #1 chk("b halted in_ready", b_if.in_ready, 0);
      tick();
      tick();
      chk("b halted out_valid", b_if.out_valid, 0);
      drv_b(0, 0, 0, 1, 1);
      tick();
      chk("b flush keeps halted", b_if.halted, 1);
      drv_b(0, 0, 0, 0, 1);

      // Halt on the skid variant: 5, 6(halt), then 7 offered after the halt.
      drv_a(1, 5, 0, 0, 1);
      tick();
      chk("a halt seq out_data 5", a_if.out_data, 5);
      chk("a halt seq out_halt 0", a_if.out_halt, 0);
      drv_a(1, 6, 1, 0, 1);
      tick();
      chk("a halt seq out_data 6", a_if.out_data, 6);
      chk("a halt seq out_halt 1", a_if.out_halt, 1);
      chk("a halt seq halted 0", a_if.halted, 0);
      drv_a(0, 0, 0, 0, 1);
      tick();
      chk("a halted", a_if.halted, 1);
      chk("a halted out_valid", a_if.out_valid, 0);
      chk("a halted in_ready", a_if.in_ready, 0);
      drv_a(1, 7, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("a 7 refused in_ready %0d", k), a_if.in_ready, 0);
         chk($sformatf("a 7 refused out_valid %0d", k), a_if.out_valid, 0);
      end
      drv_a(0, 0, 0, 1, 1);
      tick();
      chk("a flush keeps halted", a_if.halted, 1);
      drv_a(0, 0, 0, 0, 1);
      tick();
      chk("a final out_valid", a_if.out_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
